mem_dados_arbiter: RTL and testbench
====================================

Name: mem_dados_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 16x4 data memory.
- Shares the memory's single address/read/write port between requester A (processor datapath) and requester B (debug/loader port).
- Round-robin on conflict; captures read data into per-requester registers.
- Optional built-in clear sequencer zeroes the whole memory.

Parameters:
ADDR_W, 4, memory address width; depth = 2**ADDR_W
DATA_W, 4, memory data width

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-high reset
req_a  in  1  requester A access request, held until gnt_a
we_a  in  1  A: 1 = write, 0 = read
addr_a  in  ADDR_W  A address
wdata_a  in  DATA_W  A write data
gnt_a  out  1  A granted this cycle (combinational)
rvalid_a  out  1  A read data valid (registered, 1-cycle pulse)
rdata_a  out  DATA_W  A captured read data
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for requester B
clear_start  in  1  pulse: start memory clear
busy  out  1  clear in progress
mem_endereco  out  ADDR_W  to memory address
mem_write  out  1  to memory write
mem_read  out  1  to memory read
mem_dado_in  out  DATA_W  to memory write data
mem_dado_out  in  DATA_W  from memory read data

Behaviour:
- Clock and reset: one clock, `clock`; reset is asynchronous and active-high, `reset`.
- Reset values: state=IDLE, last_grant=B, clr_cnt=0, rvalid_a/b=0, rdata_a/b=0, busy=0.
- FSM states: IDLE, CLEAR.
- IDLE, arbitration (combinational, same cycle):
  - Only req_a → gnt_a. Only req_b → gnt_b.
  - Both → grant the requester not in last_grant.
  - last_grant updates at posedge to the granted side; it is unchanged when nothing is granted.
- Memory drive in IDLE:
  - Granted write: mem_endereco=addr_x, mem_dado_in=wdata_x, mem_write=1, mem_read=0. Data commits at that posedge.
  - Granted read: mem_read=1, mem_write=0. mem_dado_out is sampled into rdata_x at that posedge; rvalid_x=1 for exactly the next cycle.
  - Read latency: 1 cycle from grant.
- No grant: mem_write=0, mem_read=0, mem_endereco=0, mem_dado_in=0 (memory output floats and is never sampled).
- Handshake: a requester holds req/we/addr/wdata stable until it sees gnt. It may drop req or issue a new request the cycle after gnt. Back-to-back grants to the same side are allowed when the other side is idle.
- rdata_x holds its value until the next read by the same requester. Writes never alter rdata_x; rvalid_x stays 0 on writes.
- IDLE→CLEAR: on clear_start=1, only with MEM_CLEAR_EN. clear_start wins over any request that cycle: no gnt, no memory access.
- CLEAR:
  - busy=1, gnt_a=gnt_b=0, mem_write=1, mem_read=0, mem_endereco=clr_cnt, mem_dado_in=0.
  - clr_cnt increments each cycle.
  - When clr_cnt = 2**ADDR_W-1, that write completes, then → IDLE with clr_cnt wrapping to 0. Clear takes 16 cycles at default.
  - clear_start during CLEAR is ignored; it does not restart the sweep.
- Reset mid-clear: immediately IDLE, sweep abandoned, partial contents remain.
- Reset with a read outstanding: rvalid is dropped, no pulse.
- Pending requests during CLEAR stay pending and arbitrate normally on the first IDLE cycle.

Optional Feature:
MEM_CLEAR_EN
- Defined: CLEAR state, clr_cnt and busy logic are compiled in as described.
- Undefined: the clear_start port still exists but is ignored; busy is tied 0; the FSM is IDLE only; no counter is synthesized.

Decomposition:
- Package mem_dados_pkg: ADDR_W/DATA_W defaults, typedef enum logic {ST_IDLE, ST_CLEAR} arb_state_t, typedef enum logic {SEL_A, SEL_B} sel_t.
- One sub-module, rr_arb2: combinational 2-way round-robin grant from req_a, req_b, last_grant.
- The top holds the FSM, datapath muxes and read capture registers.
- The bench instantiates the existing 16x4 data memory as the downstream model.

Test Plan:
- Single access: A writes addr 3 = 4'hA, then A reads addr 3 → gnt_a same cycle each; next cycle rvalid_a=1, rdata_a=4'hA; rvalid_b stays 0.
- Conflict: req_a and req_b both held after reset (A writes addr 1 = 4'h5, B reads addr 1) → A granted first, B the next cycle; rdata_b=4'h5 with rvalid_b one cycle after gnt_b.
- Sustained contention: both requesting for 6 cycles → grants alternate A,B,A,B,A,B; no side is starved.
- Clear (MEM_CLEAR_EN): preload all addresses with 4'hF, pulse clear_start with req_a held → busy=1 for exactly 16 cycles, no gnt during clear; gnt_a on the first cycle after; reads of addr 0..15 all return 0.
- Reset mid-clear: assert reset at clear cycle 5 → busy drops asynchronously; addr 0..4 read 0, addr 5..15 still 4'hF.
- Without MEM_CLEAR_EN: pulse clear_start with req_b held → busy stays 0, gnt_b in the same cycle, memory contents unchanged.

Source files
------------

// File: rtl/mem_dados_arbiter_pkg.sv
// Shared widths and enums for the data-memory arbiter slice.
package mem_dados_pkg;

  localparam int unsigned MEM_ADDR_W = 4;
  localparam int unsigned MEM_DATA_W = 4;

  typedef enum logic {ST_IDLE, ST_CLEAR} arb_state_t;
  typedef enum logic {SEL_A, SEL_B} sel_t;

endpackage

// File: rtl/mem_dados_arbiter_if.sv
// One requester's access channel into the data-memory arbiter.
interface mem_dados_arbiter_if #(
  parameter int unsigned ADDR_W = mem_dados_pkg::MEM_ADDR_W,
  parameter int unsigned DATA_W = mem_dados_pkg::MEM_DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_dados_arbiter_rr_arb2.sv
// Two-way round-robin grant: on conflict the side not granted last wins.
module rr_arb2
  import mem_dados_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  sel_t last_grant,
  output logic gnt_a_c,
  output logic gnt_b_c
);

  // Grant decision, purely combinational
  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (req_a && req_b) begin
      if (last_grant == SEL_A) gnt_b_c = 1'b1;
      else                     gnt_a_c = 1'b1;
    end else begin
      gnt_a_c = req_a;
      gnt_b_c = req_b;
    end
  end

endmodule

// File: rtl/mem_dados_arbiter.sv
// Arbiter/sequencer sharing the single data-memory port between requesters
// A and B. Optional memory clear sweep compiled in with MEM_CLEAR_EN.
module mem_dados_arbiter
  import mem_dados_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic                      clock,
  input  logic                      reset,
  mem_dados_arbiter_if.slave        port_a,
  mem_dados_arbiter_if.slave        port_b,
  input  logic                      clear_start,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_endereco,
  output logic                      mem_write,
  output logic                      mem_read,
  output logic [DATA_W-1:0]         mem_dado_in,
  input  logic [DATA_W-1:0]         mem_dado_out
);

  arb_state_t        state;
  arb_state_t        next_state;
  sel_t              last_grant;
  logic              arb_a_c;
  logic              arb_b_c;
  logic              gnt_a_c;
  logic              gnt_b_c;
  logic              clear_go_c;
  logic              rvalid_a_q;
  logic              rvalid_b_q;
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  rr_arb2 u_rr (
    .req_a      (port_a.req),
    .req_b      (port_b.req),
    .last_grant (last_grant),
    .gnt_a_c    (arb_a_c),
    .gnt_b_c    (arb_b_c)
  );

`ifdef MEM_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  logic [ADDR_W-1:0] clr_cnt;

  assign clear_go_c = clear_start;
  assign busy       = (state == ST_CLEAR);

  // Sweep address counter, wraps to 0 after the last location
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
  end

  // Next-state: enter sweep on clear_start, leave after the last write
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (clear_start)           next_state = ST_CLEAR;
      ST_CLEAR: if (clr_cnt == CLR_LAST)   next_state = ST_IDLE;
      default:                             next_state = ST_IDLE;
    endcase
  end
`else
  logic unused_clear_start;

  assign unused_clear_start = clear_start;
  assign clear_go_c         = 1'b0;
  assign busy               = 1'b0;

  // Next-state: only the idle state exists in this build
  always_comb begin
    next_state = ST_IDLE;
  end
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Output decode: grants and memory port drive
  always_comb begin
    gnt_a_c      = 1'b0;
    gnt_b_c      = 1'b0;
    mem_endereco = '0;
    mem_write    = 1'b0;
    mem_read     = 1'b0;
    mem_dado_in  = '0;
    case (state)
      ST_IDLE: begin
        if (!clear_go_c) begin
          gnt_a_c = arb_a_c;
          gnt_b_c = arb_b_c;
          if (arb_a_c) begin
            mem_endereco = port_a.addr;
            mem_write    = port_a.we;
            mem_read     = !port_a.we;
            mem_dado_in  = port_a.we ? port_a.wdata : '0;
          end else if (arb_b_c) begin
            mem_endereco = port_b.addr;
            mem_write    = port_b.we;
            mem_read     = !port_b.we;
            mem_dado_in  = port_b.we ? port_b.wdata : '0;
          end
        end
      end
`ifdef MEM_CLEAR_EN
      ST_CLEAR: begin
        mem_endereco = clr_cnt;
        mem_write    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Remember who was served last; hold when nobody was granted
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        last_grant <= SEL_B;
    else if (gnt_a_c) last_grant <= SEL_A;
    else if (gnt_b_c) last_grant <= SEL_B;
  end

  // Read capture for requester A
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid_a_q <= 1'b0;
      rdata_a_q  <= '0;
    end else begin
      rvalid_a_q <= gnt_a_c && !port_a.we;
      if (gnt_a_c && !port_a.we) rdata_a_q <= mem_dado_out;
    end
  end

  // Read capture for requester B
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid_b_q <= 1'b0;
      rdata_b_q  <= '0;
    end else begin
      rvalid_b_q <= gnt_b_c && !port_b.we;
      if (gnt_b_c && !port_b.we) rdata_b_q <= mem_dado_out;
    end
  end

  assign port_a.gnt    = gnt_a_c;
  assign port_b.gnt    = gnt_b_c;
  assign port_a.rvalid = rvalid_a_q;
  assign port_b.rvalid = rvalid_b_q;
  assign port_a.rdata  = rdata_a_q;
  assign port_b.rdata  = rdata_b_q;

endmodule

// File: tb/tb_mem_dados_arbiter.sv
// Self-checking bench for mem_dados_arbiter with a 16x4 memory model.
// Clear-sweep sequences are exercised when MEM_CLEAR_EN is defined.
module tb_mem_dados_arbiter;
  import mem_dados_pkg::*;

  localparam int unsigned AW    = MEM_ADDR_W;
  localparam int unsigned DW    = MEM_DATA_W;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear_start;
  logic          busy;
  logic [AW-1:0] mem_endereco;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_dado_in;
  logic [DW-1:0] mem_dado_out;

  mem_dados_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
  mem_dados_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();

  mem_dados_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .port_a       (ia.slave),
    .port_b       (ib.slave),
    .clear_start  (clear_start),
    .busy         (busy),
    .mem_endereco (mem_endereco),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_dado_in  (mem_dado_in),
    .mem_dado_out (mem_dado_out)
  );

  always #5 clock = ~clock;

  // Downstream 16x4 data memory: synchronous write, asynchronous read
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clock) if (mem_write) ram[mem_endereco] <= mem_dado_in;
  assign mem_dado_out = ram[mem_endereco];

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic [DW-1:0] exp_rd_a = '0;
  logic [DW-1:0] exp_rd_b = '0;

  typedef struct {
    logic          ra;
    logic          wa;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          rb;
    logic          wb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic          ega;
    logic          egb;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_a(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ia.req = r; ia.we = w; ia.addr = a; ia.wdata = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ib.req = r; ib.we = w; ib.addr = a; ib.wdata = d;
  endtask

  task automatic idle_all();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
  endtask

  task automatic reset_sb();
    q_a.delete();
    q_b.delete();
    exp_rd_a = '0;
    exp_rd_b = '0;
  endtask

  // One clock cycle: inputs already driven at the negedge; check combinational
  // outputs, update the model/scoreboard, then check registered outputs.
  task automatic step(input logic eg_a, input logic eg_b, input logic eb);
    logic ev_a, ev_b, emw, emr;
    #1;
    ev_a = eg_a && !ia.we;
    ev_b = eg_b && !ib.we;
    emw  = eb || (eg_a && ia.we) || (eg_b && ib.we);
    emr  = ev_a || ev_b;
    check("gnt_a", 32'(ia.gnt), 32'(eg_a));
    check("gnt_b", 32'(ib.gnt), 32'(eg_b));
    check("busy", 32'(busy), 32'(eb));
    check("mem_write", 32'(mem_write), 32'(emw));
    check("mem_read", 32'(mem_read), 32'(emr));
    if (eg_a) begin
      check("mem_endereco_a", 32'(mem_endereco), 32'(ia.addr));
      if (ia.we) begin
        check("mem_dado_in_a", 32'(mem_dado_in), 32'(ia.wdata));
        model[ia.addr] = ia.wdata;
      end else q_a.push_back(model[ia.addr]);
    end
    if (eg_b) begin
      check("mem_endereco_b", 32'(mem_endereco), 32'(ib.addr));
      if (ib.we) begin
        check("mem_dado_in_b", 32'(mem_dado_in), 32'(ib.wdata));
        model[ib.addr] = ib.wdata;
      end else q_b.push_back(model[ib.addr]);
    end
    if (eb) check("mem_dado_in_clr", 32'(mem_dado_in), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("rvalid_a", 32'(ia.rvalid), 32'(ev_a));
    check("rvalid_b", 32'(ib.rvalid), 32'(ev_b));
    if (ia.rvalid && q_a.size() > 0) exp_rd_a = q_a.pop_front();
    if (ib.rvalid && q_b.size() > 0) exp_rd_b = q_b.pop_front();
    check("rdata_a", 32'(ia.rdata), 32'(exp_rd_a));
    check("rdata_b", 32'(ib.rdata), 32'(exp_rd_b));
  endtask

  task automatic read_all_a();
    for (int i = 0; i < int'(DEPTH); i++) begin
      set_a(1'b1, 1'b0, AW'(i), '0);
      step(1'b1, 1'b0, 1'b0);
    end
    idle_all();
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // ra wa  aa     da     rb wb  ab     db     ga gb
    tbl[0]  = '{1'b1, 1'b1, 4'd1, 4'h5, 1'b1, 1'b0, 4'd1, 4'h0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 1'b0, 4'd1, 4'h0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 4'd3, 4'hA, 1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'd3, 4'h0, 1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 1'b1, 4'd7, 4'h6, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 4'd3, 4'h0, 1'b1, 1'b0, 4'd7, 4'h0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'd3, 4'h0, 1'b1, 1'b0, 4'd7, 4'h0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 4'd3, 4'h0, 1'b1, 1'b0, 4'd7, 4'h0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'd3, 4'h0, 1'b1, 1'b0, 4'd7, 4'h0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 4'd3, 4'h0, 1'b1, 1'b0, 4'd7, 4'h0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'd3, 4'h0, 1'b1, 1'b0, 4'd7, 4'h0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 4'd3, 4'hC, 1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 4'd3, 4'h0, 1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0};

    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

    // Reset state
    reset = 1'b1;
    clear_start = 1'b0;
    idle_all();
    repeat (2) @(negedge clock);
    #1;
    check("rst_rvalid_a", 32'(ia.rvalid), 32'd0);
    check("rst_rvalid_b", 32'(ib.rvalid), 32'd0);
    check("rst_rdata_a", 32'(ia.rdata), 32'd0);
    check("rst_rdata_b", 32'(ib.rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_endereco", 32'(mem_endereco), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Table: single access, conflict, sustained contention, rdata hold
    for (int i = 0; i < 15; i++) begin
      set_a(tbl[i].ra, tbl[i].wa, tbl[i].aa, tbl[i].da);
      set_b(tbl[i].rb, tbl[i].wb, tbl[i].ab, tbl[i].db);
      step(tbl[i].ega, tbl[i].egb, 1'b0);
    end
    idle_all();

    // Reset asserted before the capture edge of a granted read: no pulse
    set_a(1'b1, 1'b0, 4'd3, '0);
    #1;
    check("pre_rst_gnt_a", 32'(ia.gnt), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #2;
    check("rst_read_rvalid_a", 32'(ia.rvalid), 32'd0);
    check("rst_read_rdata_a", 32'(ia.rdata), 32'd0);
    idle_all();
    @(negedge clock);
    reset = 1'b0;
    reset_sb();

    // Reset right after a read was captured: rvalid dropped asynchronously
    set_a(1'b1, 1'b0, 4'd7, '0);
    #1;
    check("pre_rst2_gnt_a", 32'(ia.gnt), 32'd1);
    @(posedge clock);
    #2;
    check("cap_rvalid_a", 32'(ia.rvalid), 32'd1);
    check("cap_rdata_a", 32'(ia.rdata), 32'h6);
    reset = 1'b1;
    #1;
    check("async_rvalid_a", 32'(ia.rvalid), 32'd0);
    check("async_rdata_a", 32'(ia.rdata), 32'd0);
    idle_all();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    reset_sb();

`ifdef MEM_CLEAR_EN
    // Full clear with a pending request from A
    for (int i = 0; i < int'(DEPTH); i++) begin
      set_a(1'b1, 1'b1, AW'(i), 4'hF);
      step(1'b1, 1'b0, 1'b0);
    end
    set_a(1'b1, 1'b0, '0, '0);
    clear_start = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      clear_start = (i == 8);
      step(1'b0, 1'b0, 1'b1);
    end
    clear_start = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    read_all_a();

    // Reset during the sixth clear cycle leaves a partial sweep
    for (int i = 0; i < int'(DEPTH); i++) begin
      set_a(1'b1, 1'b1, AW'(i), 4'hF);
      step(1'b1, 1'b0, 1'b0);
    end
    idle_all();
    clear_start = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clear_start = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    #1;
    check("midclr_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midclr_busy_drop", 32'(busy), 32'd0);
    check("midclr_mem_write", 32'(mem_write), 32'd0);
    for (int i = 0; i < 5; i++) model[i] = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    reset_sb();
    read_all_a();
`else
    // clear_start ignored: B granted in the same cycle, contents intact
    set_b(1'b1, 1'b0, 4'd7, '0);
    clear_start = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    clear_start = 1'b0;
    idle_all();
    repeat (3) step(1'b0, 1'b0, 1'b0);
    read_all_a();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
